// File: rtl/dmem_responder.sv
// Single-port data memory responder for an RV32I memory stage: one outstanding
// load/store, fixed two-cycle response latency, byte/half/word access with error reporting.
module dmem_responder #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [31:0]   mem [DEPTH];

    logic [1:0]    state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    off_q, off_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rerr_q, rerr_d;
    logic [31:0]   rd_word_q, rd_word_d;

    logic          accept, illegal, misalign, oor, req_err;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic [AW-1:0] idx;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   ext;

    assign req_ready = (state_q == S_IDLE) && rst_n;
    assign accept    = req_valid && req_ready;
    assign idx       = req_addr[AW+1:2];
    assign oor       = |(req_addr >> (AW + 2));
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rerr_q;

    // Request decode: lane enables, replicated store data and the error causes.
    always_comb begin
        illegal   = 1'b0;
        misalign  = 1'b0;
        be        = 4'b0000;
        wdata_rep = req_wdata;
        case (req_funct3)
            3'b000: begin
                be        = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            3'b001: begin
                misalign  = req_addr[0];
                be        = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            3'b010: begin
                misalign = |req_addr[1:0];
                be       = 4'b1111;
            end
            3'b100: illegal = req_we;
            3'b101: begin
                illegal  = req_we;
                misalign = req_addr[0];
            end
            default: illegal = 1'b1;
        endcase
        req_err = illegal | misalign | oor;
    end

    always_comb begin
        rd_word_d = rd_word_q;
        if (accept && !req_err && !req_we)
            rd_word_d = mem[idx];
    end

    // Memory is never reset; accept already excludes the reset cycle.
    always_ff @(posedge clk) begin
        if (accept && !req_err && req_we) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
    end

    always_comb begin
        byte_sel = rd_word_q[8*off_q +: 8];
        half_sel = off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        case (f3_q)
            3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  ext = {24'd0, byte_sel};
            3'b101:  ext = {16'd0, half_sel};
            default: ext = rd_word_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ACCESS;
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    off_d   = req_addr[1:0];
                    err_d   = req_err;
                end
            end
            S_ACCESS: begin
                rdata_d = (err_q || we_q) ? 32'd0 : ext;
                rerr_d  = err_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        rd_word_q <= rd_word_d;
        if (!rst_n) begin
            state_q <= S_IDLE;
            rdata_q <= 32'd0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, memory depth in 32-bit words (power of two, 16..65536).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  load/store request from the memory stage is present.
REQ-005 SHALL have port req_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 SHALL have port req_funct3  input  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port rsp_valid  output  1  response present.
REQ-011 SHALL have port rsp_ready  input  1  requester takes the response.
REQ-012 SHALL have port rsp_rdata  output  32  load data, extended to 32 bits; 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  request rejected (misaligned, out of range, illegal funct3).

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, RESP; req_ready = 1 only in IDLE with rst_n = 1.
REQ-015 SHALL accept a request on the cycle req_valid && req_ready; transition IDLE -> ACCESS; latch we, funct3, addr[1:0], error flag.
REQ-016 SHALL flag error when: funct3 in {011,110,111}; store with funct3 in {100,101}; H/HU with addr[0]=1; W with addr[1:0]!=00; addr[31:2] >= DEPTH.
REQ-017 SHALL, for an accepted non-error store, write memory on the accept edge with byte enables: B -> lane addr[1:0]; H -> lanes {addr[1],0},{addr[1],1}; W -> all four lanes.
REQ-018 SHALL, for an accepted non-error load, issue a synchronous word read on the accept edge.
REQ-019 SHALL leave memory unmodified for any error request.
REQ-020 SHALL, in ACCESS, extract the addressed byte/half from the read word, sign-extend (B, H) or zero-extend (BU, HU), register into rsp_rdata, set rsp_err, go to RESP.
REQ-021 SHALL set rsp_valid = 1 exactly in RESP; accept at edge N gives rsp_valid high from the cycle after edge N+1 (fixed 2-cycle latency, errors included).
REQ-022 SHALL hold rsp_rdata and rsp_err stable while rsp_valid && !rsp_ready.
REQ-023 SHALL go RESP -> IDLE on rsp_valid && rsp_ready; next request accepted no earlier than the following cycle (one outstanding request, max 1 per 3 cycles).
REQ-024 SHALL ignore req_* inputs whenever req_ready = 0.
REQ-025 SHALL return new data for a load issued after a store response to the same word (read-after-write across transactions).

Reset
REQ-026 SHALL, on any clk edge with rst_n = 0: state <- IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0; req_ready 0 while rst_n = 0.
REQ-027 SHALL, on reset mid-transaction, discard any pending response; a store already written on its accept edge remains committed.
REQ-028 SHALL NOT clear memory contents on reset.

Verification
REQ-029 SHALL verify: store W 0xDEADBEEF @0x10, then load W @0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid 2 cycles after each accept.
REQ-030 SHALL verify: store B 0x80 @0x13 over 0x00000000, load B @0x13 -> 0xFFFFFF80; load BU @0x13 -> 0x00000080; load W @0x10 -> 0x80000000.
REQ-031 SHALL verify: load H @0x11 and store W @0x12 -> rsp_err 1, rsp_rdata 0, memory word @0x10 unchanged.
REQ-032 SHALL verify: load W @ DEPTH*4 -> rsp_err 1; store funct3 100 -> rsp_err 1, no write.
REQ-033 SHALL verify: rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready 0, new req_valid ignored until handshake.
REQ-034 SHALL verify: rst_n low for 1 cycle in ACCESS of a load -> no response issued, req_ready 1 the cycle after rst_n returns high.
